// File: rtl/quad_decoder.sv
// Quadrature A/B decoder with wrapping up/down position counter and sticky jump error.
// Optional input glitch filter enabled by defining QDEC_FILTER_EN.
module quad_decoder #(
  parameter int N    = 4,
  parameter int FILT = 3
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         enable,
  input  logic         a,
  input  logic         b,
  input  logic         load,
  input  logic [N-1:0] set,
  input  logic         clr_err,
  output logic [N-1:0] count,
  output logic         dir,
  output logic         step,
  output logic         err
);

  // state    | meaning
  // ST_PRIME | first edge after reset: adopt cur as prev, no decode
  // ST_TRACK | decode cur against prev every cycle
  typedef enum logic {ST_PRIME, ST_TRACK} state_t;

  state_t     state, state_nxt;
  logic       a_s1, a_s2, b_s1, b_s2;
  logic [1:0] sync, cur, prev;
  logic       move_up, move_dn, jump;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= a;
      a_s2 <= a_s1;
      b_s1 <= b;
      b_s2 <= b_s1;
    end
  end

  assign sync = {a_s2, b_s2};

`ifdef QDEC_FILTER_EN
  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]    cand, filt_val;
  logic [CW-1:0] stab_cnt;

  // stab_cnt reaching zero means cand has been seen FILT clocks in a row
  always_ff @(posedge clk) begin
    if (!res_n) begin
      cand     <= 2'b00;
      filt_val <= 2'b00;
      stab_cnt <= '0;
    end else begin
      if (stab_cnt == '0) filt_val <= cand;
      if (sync != cand) begin
        cand     <= sync;
        stab_cnt <= CW'(FILT - 1);
      end else if (stab_cnt != '0) begin
        stab_cnt <= stab_cnt - CW'(1);
      end
    end
  end

  assign cur = (stab_cnt == '0) ? cand : filt_val;
`else
  localparam int unused_filt = FILT;

  assign cur = sync;
`endif

  always_ff @(posedge clk) begin
    if (!res_n) state <= ST_PRIME;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_PRIME) state_nxt = ST_TRACK;
  end

  always_comb begin
    move_up = 1'b0;
    move_dn = 1'b0;
    jump    = 1'b0;
    if (state == ST_TRACK) begin
      case ({prev, cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: move_up = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: move_dn = 1'b1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: jump    = 1'b1;
        default: ;
      endcase
    end
  end

  // load wins over any step decoded in the same cycle
  always_ff @(posedge clk) begin
    if (!res_n) begin
      prev  <= 2'b00;
      count <= '0;
      dir   <= 1'b0;
      step  <= 1'b0;
      err   <= 1'b0;
    end else begin
      prev <= cur;
      step <= 1'b0;
      if (load) begin
        count <= set;
      end else if (enable && move_up) begin
        count <= count + N'(1);
        dir   <= 1'b1;
        step  <= 1'b1;
      end else if (enable && move_dn) begin
        count <= count - N'(1);
        dir   <= 1'b0;
        step  <= 1'b1;
      end
      if (enable && jump) err <= 1'b1;
      else if (clr_err)   err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios then a random phase walk,
// all checked every cycle against a phase-index reference model.
module tb_quad_decoder;
  localparam int N    = 4;
  localparam int FILT = 3;
`ifdef QDEC_FILTER_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         res_n, enable, a, b, load, clr_err;
  logic [N-1:0] set;
  logic [N-1:0] count;
  logic         dir, step, err;

  quad_decoder #(.N(N), .FILT(FILT)) dut (
    .clk(clk), .res_n(res_n), .enable(enable), .a(a), .b(b),
    .load(load), .set(set), .clr_err(clr_err),
    .count(count), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] hist [0:7];
  int         m_count;
  bit         m_dir, m_step, m_err, m_primed;
  logic [1:0] m_prev, m_acc;
  logic [1:0] gray [0:3];
  int         ph_i;
  int         saved;

  function automatic int idx(logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(logic [1:0] ph, logic en, logic ld, logic [N-1:0] sv, logic clr, logic rn);
    logic [1:0] c;
    int         d;
    bit         same;
    {a, b} = ph; enable = en; load = ld; set = sv; clr_err = clr; res_n = rn;
    for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = ph;
    @(posedge clk);
    if (FE) begin
      same = 1'b1;
      for (int i = 1; i < FILT; i++) if (hist[3+i] !== hist[3]) same = 1'b0;
      if (same) m_acc = hist[3];
      c = m_acc;
    end else begin
      c = hist[2];
    end
    if (!rn) begin
      m_count = 0; m_dir = 0; m_step = 0; m_err = 0; m_primed = 0;
      m_prev = 2'b00; m_acc = 2'b00;
    end else begin
      m_step = 0;
      d = (idx(c) - idx(m_prev) + 4) % 4;
      if (!m_primed) begin
        m_primed = 1;
        d = 0;
      end
      if (ld) m_count = int'(sv);
      else if (en && d == 1) begin m_count = (m_count + 1) % (1 << N); m_dir = 1; m_step = 1; end
      else if (en && d == 3) begin m_count = (m_count + (1 << N) - 1) % (1 << N); m_dir = 0; m_step = 1; end
      if (en && d == 2) m_err = 1;
      else if (clr)     m_err = 0;
      m_prev = c;
    end
    #1;
    check("count", 32'(count), 32'(m_count));
    check("dir",   32'(dir),   32'(m_dir));
    check("step",  32'(step),  32'(m_step));
    check("err",   32'(err),   32'(m_err));
  endtask

  task automatic seg(int n, logic en, int ld_at, logic [N-1:0] sv, int clr_at);
    for (int i = 0; i < n; i++) tick(gray[ph_i], en, i == ld_at, sv, i == clr_at, 1'b1);
  endtask

  initial begin
    gray[0] = 2'b00; gray[1] = 2'b10; gray[2] = 2'b11; gray[3] = 2'b01;
    for (int i = 0; i < 8; i++) hist[i] = 2'b00;
    m_acc = 2'b00; m_prev = 2'b00; ph_i = 0;
    m_count = 0; m_dir = 0; m_step = 0; m_err = 0; m_primed = 0;

    tick(2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    tick(2'b00, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    seg(3, 1'b1, -1, '0, -1);
    check("reset_count", 32'(count), 32'd0);

    for (int s = 0; s < 15; s++) begin ph_i = (ph_i + 1) % 4; seg(4, 1'b1, -1, '0, -1); end
    check("up_15", 32'(count), 32'd15);
    ph_i = (ph_i + 1) % 4; seg(4, 1'b1, -1, '0, -1);
    check("up_wrap", 32'(count), 32'd0);

    for (int s = 0; s < 17; s++) begin ph_i = (ph_i + 3) % 4; seg(4, 1'b1, -1, '0, -1); end
    check("down_wrap", 32'(count), 32'd15);

    ph_i = (ph_i + 1) % 4; seg(4, 1'b1, 2, 4'd15, -1);
    check("load_15", 32'(count), 32'd15);
    for (int s = 0; s < 3; s++) begin ph_i = (ph_i + 3) % 4; seg(4, 1'b1, -1, '0, -1); end
    check("load_down", 32'(count), 32'd12);

    saved = int'(count);
    ph_i = (ph_i + 2) % 4; seg(4, 1'b1, -1, '0, -1);
    check("jump_err", 32'(err), 32'd1);
    check("jump_count", 32'(count), 32'(saved));
    seg(4, 1'b1, -1, '0, 0);
    check("clr_err", 32'(err), 32'd0);
    ph_i = (ph_i + 2) % 4; seg(4, 1'b1, -1, '0, 2);
    check("err_prio", 32'(err), 32'd1);
    seg(2, 1'b1, -1, '0, 0);

    saved = int'(count);
    for (int s = 0; s < 4; s++) begin ph_i = (ph_i + 1) % 4; seg(4, 1'b0, -1, '0, -1); end
    check("disabled_frozen", 32'(count), 32'(saved));
    seg(4, 1'b1, -1, '0, -1);
    check("reenable_static", 32'(count), 32'(saved));

    ph_i = 0; seg(8, 1'b1, -1, '0, -1);
    saved = int'(count);
    tick(2'b10, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    tick(2'b10, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    seg(8, 1'b1, -1, '0, -1);
    check("glitch", 32'(count), 32'(saved));

    for (int s = 0; s < 60; s++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)       ph_i = (ph_i + 1) % 4;
      else if (r < 8)  ph_i = (ph_i + 3) % 4;
      else if (r == 8) ph_i = (ph_i + 2) % 4;
      seg($urandom_range(4, 6), $urandom_range(0, 5) != 0,
          ($urandom_range(0, 7) == 0) ? 2 : -1, N'($urandom),
          ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
